// File: rtl/reaction_pkg.sv
// Shared types and default parameter values for the reaction timer.
package reaction_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TIMING  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_e;

    localparam int TICK_DIV_DEF   = 25000;
    localparam int TIMEOUT_MS_DEF = 2000;
    localparam int RESULT_W_DEF   = 12;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and pulses tick_o on the last count.
module ms_tick_gen #(
    parameter int TICK_DIV = 25000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = ~clr_i & (cnt_q == LAST);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: measures ms from target-strobe rise to button press.
// Optional running average of the last four results under macro REACTION_AVG_EN.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
    parameter int RESULT_W   = RESULT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stim_i,
    input  logic                press_i,
    output logic                valid_o,
    output logic [RESULT_W-1:0] time_ms_o,
    output logic                false_start_o,
    output logic                timeout_o,
    output logic [RESULT_W-1:0] best_ms_o,
    output logic                busy_o,
    output logic [RESULT_W-1:0] avg_ms_o
);

    localparam logic [RESULT_W-1:0] TIMEOUT_V = RESULT_W'(TIMEOUT_MS);

    function automatic logic [RESULT_W-1:0] sat_inc(input logic [RESULT_W-1:0] v);
        return (v == '1) ? v : v + RESULT_W'(1);
    endfunction

    state_e              state_q, state_d;
    logic                stim_q;
    logic [RESULT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [RESULT_W-1:0] time_q, time_d;
    logic [RESULT_W-1:0] best_q, best_d;
    logic                valid_q, valid_d;
    logic                fs_q, fs_d;
    logic                to_q, to_d;
    logic                rise;
    logic                tick;

    assign rise = stim_i & ~stim_q;

    // The prescaler is held at zero outside S_TIMING, so each measurement starts phase-aligned.
    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (state_q != S_TIMING),
        .tick_o  (tick)
    );

    always_comb begin
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        time_d   = time_q;
        best_d   = best_q;
        valid_d  = 1'b0;
        fs_d     = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d  = S_TIMING;
                    ms_cnt_d = '0;
                end else if (press_i) begin
                    fs_d = 1'b1;
                end
            end
            S_TIMING: begin
                // A press in the timeout cycle still counts as a valid result.
                if (press_i) begin
                    valid_d = 1'b1;
                    time_d  = ms_cnt_q;
                    if (ms_cnt_q < best_q) begin
                        best_d = ms_cnt_q;
                    end
                    state_d = S_HOLDOFF;
                end else if (ms_cnt_q == TIMEOUT_V) begin
                    to_d    = 1'b1;
                    time_d  = TIMEOUT_V;
                    state_d = S_HOLDOFF;
                end else if (tick) begin
                    ms_cnt_d = sat_inc(ms_cnt_q);
                end
            end
            S_HOLDOFF: begin
                if (!stim_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            stim_q   <= 1'b0;
            ms_cnt_q <= '0;
            time_q   <= '0;
            best_q   <= '1;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            stim_q   <= stim_i;
            ms_cnt_q <= ms_cnt_d;
            time_q   <= time_d;
            best_q   <= best_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            to_q     <= to_d;
        end
    end

    assign valid_o       = valid_q;
    assign time_ms_o     = time_q;
    assign false_start_o = fs_q;
    assign timeout_o     = to_q;
    assign best_ms_o     = best_q;
    assign busy_o        = (state_q == S_TIMING);

`ifdef REACTION_AVG_EN
    logic [RESULT_W-1:0] hist_q [4];
    logic [RESULT_W+1:0] sum_q;

    // Running sum drops the oldest entry and adds the newest, one cycle after the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            sum_q <= '0;
        end else if (valid_q) begin
            hist_q[0] <= time_q;
            for (int i = 1; i < 4; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            sum_q <= sum_q - {2'b00, hist_q[3]} + {2'b00, time_q};
        end
    end

    assign avg_ms_o = sum_q[RESULT_W+1:2];
`else
    assign avg_ms_o = '0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Randomised self-checking bench for reaction_timer against a transaction-level model.
module tb_reaction_timer;

    localparam int TD = 4;
    localparam int TO = 20;
    localparam int RW = 12;
    localparam int TO_J = TO * TD + 2;   // observation index at which timeout_o appears
    localparam int LAST_PRESS = TO * TD + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stim_i;
    logic          press_i;
    logic          valid_o;
    logic [RW-1:0] time_ms_o;
    logic          false_start_o;
    logic          timeout_o;
    logic [RW-1:0] best_ms_o;
    logic          busy_o;
    logic [RW-1:0] avg_ms_o;

    reaction_timer #(
        .TICK_DIV   (TD),
        .TIMEOUT_MS (TO),
        .RESULT_W   (RW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stim_i        (stim_i),
        .press_i       (press_i),
        .valid_o       (valid_o),
        .time_ms_o     (time_ms_o),
        .false_start_o (false_start_o),
        .timeout_o     (timeout_o),
        .best_ms_o     (best_ms_o),
        .busy_o        (busy_o),
        .avg_ms_o      (avg_ms_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int best_m;
    int time_m;
    int hist_m [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_avg();
`ifdef REACTION_AVG_EN
        return (hist_m[0] + hist_m[1] + hist_m[2] + hist_m[3]) / 4;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        best_m = (1 << RW) - 1;
        time_m = 0;
        for (int i = 0; i < 4; i++) hist_m[i] = 0;
    endtask

    task automatic model_result(input int ms);
        time_m = ms;
        if (ms < best_m) best_m = ms;
        for (int i = 3; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = ms;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_fs"}, false_start_o, 0);
        check({tag, "_to"}, timeout_o, 0);
        check({tag, "_time"}, time_ms_o, 0);
        check({tag, "_best"}, best_ms_o, (1 << RW) - 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_avg"}, avg_ms_o, 0);
    endtask

    // Rise at the next edge; press d edges later (press falls in timing cycle d-1).
    task automatic trial(input int d, input bit do_press, input bit poke_holdoff,
                         input bit press_with_rise);
        stim_i  = 1'b1;
        press_i = press_with_rise;
        for (int j = 1; j <= d; j++) begin
            @(negedge clk);
            if (j == 1) begin
                press_i = 1'b0;
                check("busy_start", busy_o, 1);
                check("fs_on_rise", false_start_o, 0);
            end
            check("timeout_pulse", timeout_o, (j == TO_J));
            check("valid_early", valid_o, 0);
            if (j == TO_J) time_m = TO;
        end
        if (do_press) begin
            press_i = 1'b1;
            @(negedge clk);
            press_i = 1'b0;
            if (d <= LAST_PRESS) begin
                model_result((d - 1) / TD);
                check("valid", valid_o, 1);
            end else begin
                check("valid_late", valid_o, 0);
            end
            check("to_after_press", timeout_o, 0);
            check("fs_after_press", false_start_o, 0);
        end
        check("busy_end", busy_o, 0);
        check("time_ms", time_ms_o, time_m);
        check("best_ms", best_ms_o, best_m);
        if (poke_holdoff) begin
            press_i = 1'b1;
            @(negedge clk);
            press_i = 1'b0;
            check("holdoff_fs", false_start_o, 0);
            check("holdoff_valid", valid_o, 0);
        end
        stim_i = 1'b0;
        @(negedge clk);
        check("avg_ms", avg_ms_o, exp_avg());
        check("valid_single", valid_o, 0);
        @(negedge clk);
    endtask

    task automatic false_start();
        stim_i  = 1'b0;
        press_i = 1'b1;
        @(negedge clk);
        press_i = 1'b0;
        check("fs_pulse", false_start_o, 1);
        check("fs_valid", valid_o, 0);
        check("fs_to", timeout_o, 0);
        check("fs_time", time_ms_o, time_m);
        @(negedge clk);
        check("fs_single", false_start_o, 0);
    endtask

    task automatic async_reset_mid();
        stim_i  = 1'b1;
        press_i = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_pre_rst", busy_o, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        stim_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("busy_post_rst", busy_o, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        bit p;
        model_reset();
        reset_n = 1'b0;
        stim_i  = 1'b0;
        press_i = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        trial(30, 1, 0, 0);          // 7 ms
        false_start();
        trial(90, 0, 0, 0);          // timeout
        trial(LAST_PRESS, 1, 0, 0);  // press in the timeout cycle -> 20 ms
        async_reset_mid();

        trial(37, 1, 0, 0);          // 9
        trial(21, 1, 1, 0);          // 5, press during holdoff ignored
        false_start();               // re-arm needs a fresh rise
        trial(49, 1, 0, 0);          // 12

        async_reset_mid();
        repeat (4) trial(33, 1, 0, 0);  // 8 ms each
        trial(14, 1, 0, 1);          // rise and press together

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                false_start();
            end else begin
                d = $urandom_range(1, 95);
                p = ($urandom_range(0, 4) != 0);
                if (!p && d < TO_J + 2) d = TO_J + 2;
                trial(d, p, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
Downstream consumer of the target-second LED game. It measures the player's reaction time from the rising edge of the target strobe (the led_ext level) to the next debounced button-press pulse, in milliseconds. It reports each result with a one-cycle valid strobe, flags false starts and timeouts, and tracks the best time since reset.

Parameters:
TICK_DIV, 25000, clk cycles per millisecond tick (25 MHz clock).
TIMEOUT_MS, 2000, reaction window in ms; must be ≤ 2^RESULT_W-1.
RESULT_W, 12, width of millisecond results.

Ports:
clk  in  1  system clock
reset_n  in  1  async active-low reset
stim_i  in  1  target strobe level (led_ext), synchronous to clk
press_i  in  1  single-cycle debounced press pulse
valid_o  out  1  one-cycle pulse: time_ms_o holds a new reaction result
time_ms_o  out  RESULT_W  last result in ms, held until next valid/timeout
false_start_o  out  1  one-cycle pulse: press with no armed stimulus
timeout_o  out  1  one-cycle pulse: no press within TIMEOUT_MS
best_ms_o  out  RESULT_W  minimum valid result since reset
busy_o  out  1  high in S_TIMING
avg_ms_o  out  RESULT_W  running average (see Optional Feature)

Behaviour:
- Interface: clock clk; reset reset_n, asynchronous, active-low.
- Reset values:
  - all pulses and busy_o = 0; time_ms_o = 0; avg_ms_o = 0
  - best_ms_o = all ones
  - stim_q = 0; state = S_IDLE.
- stim_q registers stim_i. A rise is stim_i & ~stim_q.
- S_IDLE:
  - rise -> S_TIMING; prescaler and ms_cnt cleared to 0.
  - press_i -> false_start_o = 1 next cycle; stay in S_IDLE.
  - rise and press in the same cycle: rise wins (go to S_TIMING); the press is discarded with no false start.
- S_TIMING:
  - Prescaler counts 0..TICK_DIV-1. On wrap, ms_cnt increments, saturating at 2^RESULT_W-1.
  - press_i -> next cycle: valid_o = 1, time_ms_o = ms_cnt (value in the press cycle); best_ms_o updated if ms_cnt < best_ms_o; state -> S_HOLDOFF.
  - Timeout: ms_cnt == TIMEOUT_MS with no press -> next cycle: timeout_o = 1, time_ms_o = TIMEOUT_MS, best unchanged; state -> S_HOLDOFF.
  - Press and timeout in the same cycle: the press wins (valid, not timeout).
  - Further rises are ignored; no restart.
- S_HOLDOFF:
  - Presses ignored; no false start.
  - Exit to S_IDLE on the first cycle with stim_i == 0.
  - This blocks re-arming within the same strobe pulse.
- Latency: press cycle N -> valid_o in cycle N+1. Reaction quantised down to whole ms.
- Pulses never overlap: at most one of valid_o, false_start_o, timeout_o is high per cycle.
- Reset mid-S_TIMING aborts the measurement silently; all outputs return to reset values.

Optional Feature:
Macro REACTION_AVG_EN.
- Defined:
  - 4-entry shift history of valid results (timeouts excluded), each entry reset to 0.
  - Sum register RESULT_W+2 bits.
  - avg_ms_o = sum >> 2, updated the cycle after valid_o.
  - The first three averages include zero entries.
- Undefined: history logic absent; avg_ms_o tied to 0.

Decomposition:
- Package reaction_pkg: state enum (S_IDLE, S_TIMING, S_HOLDOFF) as a 2-bit logic type; default constants for TICK_DIV, TIMEOUT_MS and RESULT_W.
- One sub-module ms_tick_gen: prescaler with synchronous clear input and a one-cycle tick output, parameterised by TICK_DIV.

Test Plan (bench overrides TICK_DIV=4, TIMEOUT_MS=20, RESULT_W=12):
1. Basic measurement: stim_i rises, press_i after 30 cycles -> valid_o one cycle later; time_ms_o = 7; best_ms_o = 7; busy_o falls.
2. False start: press_i with stim_i low in S_IDLE -> false_start_o single pulse; valid_o and timeout_o stay 0.
3. Timeout: stim_i rises, no press -> timeout_o after ~81 cycles; time_ms_o = 20; best_ms_o unchanged.
4. Press/timeout race: press_i in the exact cycle ms_cnt reaches 20 -> valid_o with time_ms_o = 20; no timeout_o.
5. Best tracking and holdoff:
   - Results 9, then 5, then 12 -> best_ms_o is 9, 5, 5.
   - A press while stim_i is still high after a result -> no false_start_o.
   - A second rise is needed to re-arm.
6. Async reset: reset_n low mid-S_TIMING -> all outputs immediately at reset values; best_ms_o = 0xFFF. With REACTION_AVG_EN: results 8, 8, 8, 8 -> avg_ms_o = 2, 4, 6, 8.
